axum_dma: RTL and testbench

AXUM_DMA -- requirements
Module: axum_dma

---
 rtl/axum_dma.sv | 237 +++++++++++++++++++++++
 tb/tb_axum_dma.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axum_dma.sv
// axum_dma -- single-channel word-copy DMA engine.
//
// A register port programs SRC/DST/LEN. A START write then copies LEN 32-bit
// words from SRC to DST over a single bus-host port. The host port never has
// more than one transaction outstanding: read word, write word, repeat.
//
// Optional feature macro: AXUM_DMA_IRQ_EN
//   defined   : CTRL bit1 (IRQ_EN) is read/write, dma_intr_o = DONE & IRQ_EN
//   undefined : CTRL bit1 ignored / reads 0, dma_intr_o tied low
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   dma_req_i .. _wdata_i  register-port request (always accepted)
//   dma_rvalid_o, dma_rdata_o, dma_err_o  register-port response, 1 cycle later
//   host_req_o .. host_wdata_o  bus-host request, held until host_gnt_i
//   host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i  bus-host grant/response
//   dma_intr_o          completion interrupt (level)
//
// Register map (dma_addr_i[4:2]):
//   0 SRC, 1 DST, 2 LEN, 3 CTRL (b0 START wo, b1 IRQ_EN), 4 STATUS (b0 BUSY,
//   b1 DONE w1c, b2 ERR w1c); 5..7 respond with err=1.
module axum_dma #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dma_req_i,
  input  logic                    dma_we_i,
  input  logic [3:0]              dma_be_i,
  input  logic [AddressWidth-1:0] dma_addr_i,
  input  logic [31:0]             dma_wdata_i,
  output logic                    dma_rvalid_o,
  output logic [31:0]             dma_rdata_o,
  output logic                    dma_err_o,
  output logic                    host_req_o,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [31:0]             host_wdata_o,
  input  logic                    host_gnt_i,
  input  logic                    host_rvalid_i,
  input  logic [31:0]             host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_intr_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_e;

  state_e state_q, state_d;

  // Programmed registers
  logic [AddressWidth-1:0] src_q, dst_q;
  logic [LenWidth-1:0]     len_q;
  logic                    done_q, err_q;
  logic                    irq_en;

  // Working copies used by the transfer
  logic [AddressWidth-1:0] cur_src_q, cur_dst_q;
  logic [LenWidth-1:0]     remaining_q;
  logic [31:0]             data_q;

  logic [2:0]  reg_off;
  logic        reg_hit, reg_wr, busy, start;
  logic [31:0] rd_val, wr_merged;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign reg_off = dma_addr_i[4:2];
  assign reg_hit = (reg_off <= 3'd4);
  assign reg_wr  = dma_req_i & dma_we_i;
  assign busy    = (state_q != IDLE);
  assign start   = reg_wr & (reg_off == 3'd3) & dma_be_i[0] & dma_wdata_i[0] & ~busy;

  logic unused_addr;
  assign unused_addr = ^{dma_addr_i[AddressWidth-1:5], dma_addr_i[1:0]};

  always_comb begin
    rd_val = '0;
    case (reg_off)
      3'd0:    rd_val = 32'(src_q);
      3'd1:    rd_val = 32'(dst_q);
      3'd2:    rd_val = 32'(len_q);
      3'd3:    rd_val = {30'b0, irq_en, 1'b0};
      3'd4:    rd_val = {29'b0, err_q, done_q, busy};
      default: rd_val = '0;
    endcase
  end

  // Byte-enable merge against the register currently addressed.
  assign wr_merged = be_merge(rd_val, dma_wdata_i, dma_be_i);

  // Next state and host request outputs
  always_comb begin
    state_d      = state_q;
    host_req_o   = 1'b0;
    host_addr_o  = '0;
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (start && (len_q != '0)) state_d = RD_REQ;
      end
      RD_REQ: begin
        host_req_o  = 1'b1;
        host_be_o   = 4'hF;
        host_addr_o = cur_src_q;
        if (host_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (host_rvalid_i) state_d = host_err_i ? IDLE : WR_REQ;
      end
      WR_REQ: begin
        host_req_o   = 1'b1;
        host_we_o    = 1'b1;
        host_be_o    = 4'hF;
        host_addr_o  = cur_dst_q;
        host_wdata_o = data_q;
        if (host_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i || (remaining_q == LenWidth'(1))) state_d = IDLE;
          else                                            state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dma_rvalid_o <= 1'b0;
      dma_rdata_o  <= '0;
      dma_err_o    <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cur_src_q    <= '0;
      cur_dst_q    <= '0;
      remaining_q  <= '0;
      data_q       <= '0;
    end else begin
      dma_rvalid_o <= dma_req_i;
      dma_err_o    <= dma_req_i & ~reg_hit;
      dma_rdata_o  <= (dma_req_i && !dma_we_i && reg_hit) ? rd_val : '0;

      if (reg_wr && !busy) begin
        case (reg_off)
          3'd0:    src_q <= AddressWidth'(wr_merged) & ~AddressWidth'(3);
          3'd1:    dst_q <= AddressWidth'(wr_merged) & ~AddressWidth'(3);
          3'd2:    len_q <= LenWidth'(wr_merged);
          default: ;
        endcase
      end

      if (reg_wr && (reg_off == 3'd4) && dma_be_i[0]) begin
        if (dma_wdata_i[1]) done_q <= 1'b0;
        if (dma_wdata_i[2]) err_q  <= 1'b0;
      end

      // A zero-length START completes on the spot without touching the bus.
      if (start) begin
        done_q      <= (len_q == '0);
        err_q       <= 1'b0;
        cur_src_q   <= src_q;
        cur_dst_q   <= dst_q;
        remaining_q <= len_q;
      end

      // Transfer events come last so a completion beats a same-cycle W1C.
      case (state_q)
        RD_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              err_q  <= 1'b1;
              done_q <= 1'b0;
            end else begin
              data_q <= host_rdata_i;
            end
          end
        end
        WR_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              err_q  <= 1'b1;
              done_q <= 1'b0;
            end else begin
              cur_src_q   <= cur_src_q + AddressWidth'(4);
              cur_dst_q   <= cur_dst_q + AddressWidth'(4);
              remaining_q <= remaining_q - LenWidth'(1);
              if (remaining_q == LenWidth'(1)) done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXUM_DMA_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_en_q <= 1'b0;
    else if (reg_wr && (reg_off == 3'd3) && dma_be_i[0]) irq_en_q <= dma_wdata_i[1];
  end
  assign irq_en     = irq_en_q;
  assign dma_intr_o = done_q & irq_en_q;
`else
  assign irq_en     = 1'b0;
  assign dma_intr_o = 1'b0;
`endif

endmodule

// File: tb/tb_axum_dma.sv
// Testbench for axum_dma: register-port driver, randomized bus-host slave
// with a read-only pattern memory and a transaction log, and a reference
// model that derives the expected bus sequence directly from SRC/DST/LEN.
module tb_axum_dma;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dma_req_i, dma_we_i;
  logic [3:0]  dma_be_i;
  logic [31:0] dma_addr_i, dma_wdata_i;
  logic        dma_rvalid_o, dma_err_o;
  logic [31:0] dma_rdata_o;
  logic        host_req_o, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o;
  logic [3:0]  host_be_o;
  logic        host_gnt_i, host_rvalid_i, host_err_i;
  logic [31:0] host_rdata_i;
  logic        dma_intr_o;

  always #5 clk_i = ~clk_i;

  axum_dma #(.AddressWidth(32), .LenWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_be_i(dma_be_i),
    .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
    .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o), .dma_err_o(dma_err_o),
    .host_req_o(host_req_o), .host_addr_o(host_addr_o), .host_we_o(host_we_o),
    .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
    .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .dma_intr_o(dma_intr_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- bus-host slave ----------------
  int  gnt_mode  = -1;   // -1 random 0..3 wait cycles, else fixed
  bit  zero_wait = 1'b0; // response exactly 1 cycle after grant
  int  err_kind  = 0;    // 0 none, 1 error on read #err_n, 2 on write #err_n
  int  err_n     = 0;
  int  rd_cnt, wr_cnt;
  int  last_rv_cyc;
  int  req_cycles = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit          log_we[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  initial begin
    logic [31:0] a, wd;
    logic        we;
    int          delay, lat;
    bit          ok;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = '0;
      if (host_req_o && !rst_i) begin
        a = host_addr_o; we = host_we_o; wd = host_wdata_o;
        delay = zero_wait ? 0 : ((gnt_mode >= 0) ? gnt_mode : int'($urandom_range(0, 3)));
        ok = 1'b1;
        for (int d = 0; d < delay; d++) begin
          @(negedge clk_i);
          check("hold_req", 64'(host_req_o | rst_i), 64'd1);
          if (!host_req_o) begin ok = 1'b0; break; end
          check("hold_addr", 64'(host_addr_o), 64'(a));
          check("hold_we", 64'(host_we_o), 64'(we));
          check("hold_wdata", 64'(host_wdata_o), 64'(wd));
        end
        if (ok) begin
          host_gnt_i = 1'b1;
          @(negedge clk_i);
          host_gnt_i = 1'b0;
          lat = zero_wait ? 1 : int'($urandom_range(1, 3));
          for (int l = 1; l < lat; l++) @(negedge clk_i);
          host_rvalid_i = 1'b1;
          last_rv_cyc = cyc + 1;
          log_addr.push_back(a); log_we.push_back(we); log_data.push_back(wd);
          if (!we) begin
            rd_cnt++;
            if (err_kind == 1 && rd_cnt == err_n) host_err_i = 1'b1;
            else host_rdata_i = rom(a);
          end else begin
            wr_cnt++;
            if (err_kind == 2 && wr_cnt == err_n) host_err_i = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- continuous protocol monitors ----------------
  logic req_prev = 1'b0;
  always @(posedge clk_i) req_prev <= dma_req_i & ~rst_i;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (host_req_o) begin
        req_cycles++;
        check("host_be", 64'(host_be_o), 64'hF);
      end else begin
        check("host_idle_out", 64'({host_addr_o, host_we_o, host_be_o, host_wdata_o}), 64'd0);
      end
      check("rvalid_timing", 64'(dma_rvalid_o), 64'(req_prev));
      if (!dma_rvalid_o) check("rdata_idle", 64'({dma_rdata_o, dma_err_o}), 64'd0);
    end
  end

  // ---------------- register port ----------------
  int last_req_cyc;

  // Called at a negedge; returns at the following negedge with the response.
  task automatic reg_access(input bit we, input logic [2:0] off, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rd, output logic er);
    logic [31:0] noise;
    noise = $urandom;
    dma_req_i = 1'b1; dma_we_i = we; dma_be_i = be; dma_wdata_i = wd;
    dma_addr_i = {noise[31:5], off, noise[1:0]};
    last_req_cyc = cyc + 1;
    @(negedge clk_i);
    dma_req_i = 1'b0; dma_we_i = 1'b0; dma_be_i = '0; dma_wdata_i = '0; dma_addr_i = '0;
    check("rvalid", 64'(dma_rvalid_o), 64'd1);
    rd = dma_rdata_o; er = dma_err_o;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] rd; logic er;
    reg_access(1'b1, off, wd, 4'hF, rd, er);
    check($sformatf("wr_err[%0d]", off), 64'(er), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    reg_access(1'b0, off, '0, 4'hF, rd, er);
    check(tag, 64'(rd), 64'(exp));
    check({tag, "_err"}, 64'(er), 64'd0);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    logic er;
    st = '1;
    for (int k = 0; k < 2000; k++) begin
      reg_access(1'b0, 3'd4, '0, 4'hF, st, er);
      if (!st[0]) break;
    end
    check("busy_timeout", 64'(st[0]), 64'd0);
  endtask

  // ---------------- transfer + reference model ----------------
  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int ek, input int en, input int gmode,
                          input bit zw, input bit irq, input bit poke);
    logic [31:0] exp_a[$], exp_d[$];
    bit          exp_w[$];
    logic [31:0] st, sa, da;
    logic [31:0] rd; logic er;
    bit          aborted;
    int          start_cyc, rc;
    gnt_mode = gmode; zero_wait = zw; err_kind = ek; err_n = en;
    rd_cnt = 0; wr_cnt = 0;
    log_addr.delete(); log_data.delete(); log_we.delete();

    wr(3'd0, src); wr(3'd1, dst); wr(3'd2, 32'(len));
    rd_chk({tag, "_src"}, 3'd0, src & ~32'd3);
    rd_chk({tag, "_len"}, 3'd2, 32'(len));
    wr(3'd3, irq ? 32'h3 : 32'h1);
    start_cyc = last_req_cyc;
    if (poke) begin
      rd_chk({tag, "_busy"}, 3'd4, 32'h1);
      wr(3'd0, 32'hDEADBEE0);
      wr(3'd3, 32'h1);
      rd_chk({tag, "_src_hold"}, 3'd0, src & ~32'd3);
    end
    wait_idle(st);

    // Expected bus sequence: word i is read from src+4i, written to dst+4i.
    aborted = 1'b0;
    sa = src & ~32'd3; da = dst & ~32'd3;
    for (int i = 0; i < len && !aborted; i++) begin
      exp_a.push_back(sa + 32'(4 * i)); exp_w.push_back(1'b0); exp_d.push_back('0);
      if (ek == 1 && en == i + 1) begin aborted = 1'b1; break; end
      exp_a.push_back(da + 32'(4 * i)); exp_w.push_back(1'b1); exp_d.push_back(rom(sa + 32'(4 * i)));
      if (ek == 2 && en == i + 1) aborted = 1'b1;
    end

    check({tag, "_ntxn"}, 64'(log_addr.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(exp_a[i]));
      check($sformatf("%s_we%0d", tag, i), 64'(log_we[i]), 64'(exp_w[i]));
      if (exp_w[i]) check($sformatf("%s_data%0d", tag, i), 64'(log_data[i]), 64'(exp_d[i]));
    end
    check({tag, "_status"}, 64'(st), aborted ? 64'h4 : 64'h2);
    if (zw && !aborted && len > 0)
      check({tag, "_cycles"}, 64'(last_rv_cyc - start_cyc), 64'(4 * len));
`ifdef AXUM_DMA_IRQ_EN
    check({tag, "_intr"}, 64'(dma_intr_o), 64'(irq && !aborted));
`else
    check({tag, "_intr"}, 64'(dma_intr_o), 64'd0);
`endif
    rc = req_cycles;
    repeat (5) @(negedge clk_i);
    check({tag, "_quiet"}, 64'(req_cycles), 64'(rc));
    reg_access(1'b0, 3'd3, '0, 4'hF, rd, er);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, r1, r2, expv, st;
    logic [3:0]  be;
    logic        er;
    int          len, ek, en;
    dma_req_i = 1'b0; dma_we_i = 1'b0; dma_be_i = '0; dma_addr_i = '0; dma_wdata_i = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_host_req", 64'(host_req_o), 64'd0);
    check("rst_rvalid", 64'(dma_rvalid_o), 64'd0);
    check("rst_intr", 64'(dma_intr_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    rd_chk("rst_src", 3'd0, 32'h0);
    rd_chk("rst_dst", 3'd1, 32'h0);
    rd_chk("rst_len", 3'd2, 32'h0);
    rd_chk("rst_ctrl", 3'd3, 32'h0);
    rd_chk("rst_status", 3'd4, 32'h0);

    // Byte-enable writes, low address bits forced to zero
    for (int i = 0; i < 4; i++) begin
      r1 = $urandom; r2 = $urandom; be = 4'($urandom_range(1, 15));
      wr(3'd0, r1);
      reg_access(1'b1, 3'd0, r2, be, rd, er);
      expv = r1;
      for (int b = 0; b < 4; b++) if (be[b]) expv[8*b +: 8] = r2[8*b +: 8];
      rd_chk($sformatf("be_src%0d", i), 3'd0, expv & ~32'd3);
      wr(3'd2, r1);
      reg_access(1'b1, 3'd2, r2, be, rd, er);
      rd_chk($sformatf("be_len%0d", i), 3'd2, {16'h0, expv[15:0]});
    end

    // Unmapped offsets
    wr(3'd0, 32'h0000_1234);
    reg_access(1'b0, 3'd5, '0, 4'hF, rd, er);
    check("unmapped_rd_err", 64'(er), 64'd1);
    check("unmapped_rd_data", 64'(rd), 64'd0);
    reg_access(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("unmapped_wr_err", 64'(er), 64'd1);
    rd_chk("unmapped_nochg", 3'd0, 32'h0000_1234);

    // Directed transfers
    run_xfer("basic", 32'h0010_0000, 32'h0010_0400, 4, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h1);
    rd_chk("len0_status", 3'd4, 32'h2);
    run_xfer("len0", 32'h0010_0000, 32'h0010_0400, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_xfer("rderr", 32'h0020_0000, 32'h0030_0000, 3, 1, 2, 0, 1'b1, 1'b0, 1'b0);
    wr(3'd4, 32'h4);
    rd_chk("err_clear", 3'd4, 32'h0);
    run_xfer("wrerr", 32'h0020_0100, 32'h0030_0100, 3, 2, 2, -1, 1'b0, 1'b0, 1'b0);
    run_xfer("gntdly", 32'h0040_0000, 32'h0050_0000, 3, 0, 0, 5, 1'b0, 1'b0, 1'b1);
    run_xfer("wrap", 32'hFFFF_FFFC, 32'h0060_0000, 2, 0, 0, 0, 1'b1, 1'b0, 1'b0);

    // Interrupt
    run_xfer("irq", 32'h0070_0000, 32'h0080_0000, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
`ifdef AXUM_DMA_IRQ_EN
    rd_chk("irq_ctrl", 3'd3, 32'h2);
    wr(3'd4, 32'h2);
    check("irq_clear", 64'(dma_intr_o), 64'd0);
`else
    rd_chk("irq_ctrl", 3'd3, 32'h0);
    check("irq_tied", 64'(dma_intr_o), 64'd0);
`endif

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      len = int'($urandom_range(1, 6));
      ek  = int'($urandom_range(0, 2));
      en  = int'($urandom_range(1, len));
      run_xfer($sformatf("rnd%0d", t),
               32'h1000_0000 + ($urandom_range(0, 255) << 2),
               32'h2000_0000 + ($urandom_range(0, 255) << 2),
               len, ek, en, -1, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a transfer
    gnt_mode = 5; zero_wait = 1'b0; err_kind = 0;
    wr(3'd0, 32'h0090_0000); wr(3'd1, 32'h00A0_0000); wr(3'd2, 32'd8);
    wr(3'd3, 32'h1);
    for (int k = 0; k < 50; k++) begin
      if (host_req_o) break;
      @(negedge clk_i);
    end
    check("mid_rst_req_seen", 64'(host_req_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_req", 64'(host_req_o), 64'd0);
    check("mid_rst_addr", 64'(host_addr_o), 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    rd_chk("mid_rst_status", 3'd4, 32'h0);
    rd_chk("mid_rst_src", 3'd0, 32'h0);
    st = '0;
    repeat (5) @(negedge clk_i);
    check("mid_rst_idle", 64'(host_req_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
